// File: rtl/alu_entry_sequencer.sv
`timescale 1ns/1ps
// alu_entry_sequencer
// Operand/opcode entry controller for a 2-bit-opcode ALU. The user keys values on
// DataIn and confirms each with Enter (A -> B -> opcode). Undo steps back one stage.
// One cycle after the opcode is committed, the ALU Result/Status are captured and
// held for display until the next Enter or Undo.
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   DataIn         entry value (operand, or opcode in DataIn[1:0])
//   Enter, Undo    debounced button levels; rising edges are the events
//   AluResult      ALU result (combinational from OperandA/OperandB/OpCode)
//   AluStatus      ALU status {N,C,Z,V}
//   OperandA/B     registered operands to the ALU
//   OpCode         registered opcode to the ALU (0 ADD, 1 SUB, 2 OR, 3 AND)
//   DisplayValue   combinational value for the 7-segment display
//   StatusOut      held {N,C,Z,V} of the last completed operation, 0 outside SHOW
//   CurrentState   FSM state encoding for LEDs
module alu_entry_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Enter,
    input  logic             Undo,
    input  logic [WIDTH-1:0] AluResult,
    input  logic [3:0]       AluStatus,
    output logic [WIDTH-1:0] OperandA,
    output logic [WIDTH-1:0] OperandB,
    output logic [1:0]       OpCode,
    output logic [WIDTH-1:0] DisplayValue,
    output logic [3:0]       StatusOut,
    output logic [2:0]       CurrentState
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned STAT_W = 4;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t              state, state_next;
    logic                enter_q, undo_q;
    logic [WIDTH-1:0]    opa_q, opa_next;
    logic [WIDTH-1:0]    opb_q, opb_next;
    logic [OP_W-1:0]     opc_q, opc_next;
    logic [WIDTH-1:0]    result_q, result_next;
    logic [STAT_W-1:0]   status_q, status_next;
    logic                enter_ev, undo_ev;

    // Rising-edge detection; history resets high so a button held through reset never fires
    assign enter_ev = Enter & ~enter_q;
    assign undo_ev  = Undo  & ~undo_q;

    // State, history and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT_A;
            enter_q  <= 1'b1;
            undo_q   <= 1'b1;
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state    <= state_next;
            enter_q  <= Enter;
            undo_q   <= Undo;
            opa_q    <= opa_next;
            opb_q    <= opb_next;
            opc_q    <= opc_next;
            result_q <= result_next;
            status_q <= status_next;
        end
    end

    // Next-state and register-update logic; Undo takes priority over Enter
    always_comb begin
        state_next  = state;
        opa_next    = opa_q;
        opb_next    = opb_q;
        opc_next    = opc_q;
        result_next = result_q;
        status_next = status_q;
        case (state)
            WAIT_A: begin
                if (!undo_ev && enter_ev) begin
                    opa_next   = DataIn;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (undo_ev) begin
                    state_next = WAIT_A;
                end else if (enter_ev) begin
                    opb_next   = DataIn;
                    state_next = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (undo_ev) begin
                    state_next = WAIT_B;
                end else if (enter_ev) begin
                    opc_next   = DataIn[OP_W-1:0];
                    state_next = CALC;
                end
            end
            CALC: begin
                // ALU inputs have settled for a full cycle; button events here are dropped
                result_next = AluResult;
                status_next = AluStatus;
                state_next  = SHOW;
            end
            SHOW: begin
                if (undo_ev) begin
                    status_next = '0;
                    state_next  = WAIT_OP;
                end else if (enter_ev) begin
                    status_next = '0;
                    state_next  = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase
    end

    // Display source selection per state
    always_comb begin
        DisplayValue = '0;
        case (state)
            WAIT_A, WAIT_B: DisplayValue = DataIn;
            WAIT_OP:        DisplayValue = {{(WIDTH-OP_W){1'b0}}, DataIn[OP_W-1:0]};
            CALC:           DisplayValue = AluResult;
            SHOW:           DisplayValue = result_q;
            default:        DisplayValue = '0;
        endcase
    end

    assign OperandA     = opa_q;
    assign OperandB     = opb_q;
    assign OpCode       = opc_q;
    assign StatusOut    = status_q;
    assign CurrentState = state;

endmodule
